stream_demux1xn: RTL
====================

STREAM_DEMUX1XN -- requirements
Module: stream_demux1xn

Interface
REQ-001 Parameter N, default 4, number of output channels (legal range 2..16).
REQ-002 Parameter W, default 8, data width in bits (legal range 1..64).
REQ-003 Parameter SW, default max(1, clog2(N)), select width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous and active-low.
REQ-006 EN  input  1  enable; 1 allows new input acceptance.
REQ-007 S  input  SW  channel select for the current input beat.
REQ-008 I_DATA  input  W  input data.
REQ-009 I_VALID  input  1  input beat present.
REQ-010 I_READY  output  1  block can accept the input beat this cycle.
REQ-011 M_DATA  output  N*W  channel k data at bits [k*W +: W].
REQ-012 M_VALID  output  N  per-channel output valid.
REQ-013 M_READY  input  N  per-channel downstream ready.
REQ-014 DROP_CNT  output  8  count of beats accepted with out-of-range select.

Function
REQ-015 Each channel SHALL hold a one-entry output register (data + valid).
REQ-016 Slot k is free when M_VALID[k]=0 or M_READY[k]=1 in the same cycle.
REQ-017 I_READY SHALL be combinational: EN=1 and (S>=N or slot S free); I_READY SHALL be 0 whenever EN=0.
REQ-018 A beat is accepted when I_VALID=1 and I_READY=1 at a rising edge.
REQ-019 An accepted beat with S<N SHALL appear on channel S on the next cycle: M_VALID[S]=1 and M_DATA[S]=I_DATA (latency 1).
REQ-020 An output beat completes when M_VALID[k]=1 and M_READY[k]=1; M_VALID[k] then clears unless reloaded in that cycle.
REQ-021 Simultaneous completion and load on the same channel: load wins; M_VALID[k] stays 1 with new data, no bubble.
REQ-022 While M_VALID[k]=1 and M_READY[k]=0, M_DATA[k] SHALL hold stable.
REQ-023 Unselected channels SHALL be unaffected by input activity; all channels drain independently.
REQ-024 EN=0 SHALL block acceptance only; held outputs still drain normally.
REQ-025 An accepted beat with S>=N (only possible when N is not a power of two) SHALL be discarded and DROP_CNT incremented by 1.
REQ-026 DROP_CNT SHALL saturate at 255 and not wrap.
REQ-027 M_DATA[k] SHALL retain its last value after M_VALID[k] clears.
REQ-028 At most one beat accepted per cycle; per-channel throughput one beat per cycle when M_READY[k]=1 continuously.

Reset
REQ-029 RST_N=0 SHALL immediately, without a clock, force M_VALID=0, M_DATA=0, DROP_CNT=0.
REQ-030 Reset mid-operation SHALL discard all held beats; no beat is presented after release until newly accepted.
REQ-031 First acceptance possible at the first rising edge with RST_N=1.

Structure
REQ-032 Package demux_pkg SHALL hold the N/W defaults, the DROP_CNT width constant (8), and the clog2 helper function.
REQ-033 One sub-module demux_slot (one-entry data/valid register with load and drain) SHALL be instantiated N times via generate.
REQ-034 Top level contains only select decode, I_READY logic and the drop counter.

Verification
REQ-035 N=4, W=8, all M_READY=1, EN=1, send 0xA5 with S=2 -> next cycle M_VALID=4'b0100, M_DATA[2]=0xA5; I_READY stays 1.
REQ-036 M_READY[1]=0, send 0x11 then 0x22 to S=1 -> first held on channel 1, I_READY=0 for the second until M_READY[1]=1, then 0x22 follows with no bubble.
REQ-037 Channel 0 stalled with 0x33, stream 0x44,0x55 to S=3 -> channel 3 delivers both back-to-back; channel 0 holds 0x33 unchanged.
REQ-038 N=3, send 300 beats with S=3 -> no M_VALID asserted, DROP_CNT=255 (saturated).
REQ-039 EN=0 with channel 2 holding data and M_READY[2]=1 -> I_READY=0, channel 2 drains in one cycle, M_VALID=0.
REQ-040 Assert RST_N=0 between clock edges with two channels full -> M_VALID=0, M_DATA=0, DROP_CNT=0 immediately; after release only new beats appear.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer.
// The drop counter width is fixed; N and W are the default channel count and data width.
package demux_pkg;

   localparam int N_DEF  = 4;
   localparam int W_DEF  = 8;
   localparam int DROP_W = 8;

   // Ceiling log2 for select-width sizing; returns 0 for v <= 1.
   function automatic int clog2_f(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register (data + valid) for a single demux channel.
// A load in the same cycle as a drain wins, so back-to-back beats see no bubble.
module demux_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         free_o
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   // Data only changes on load, so it stays stable while stalled and after draining.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign free_o  = ~valid_q | ready_i;

endmodule

// File: rtl/stream_demux1xn.sv
// 1-to-N stream demultiplexer: routes each accepted beat to the channel named by s.
// Beats whose select is out of range are accepted, discarded and counted (saturating).
module stream_demux1xn
   import demux_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int W  = W_DEF,
   parameter int SW = (clog2_f(N) > 1) ? clog2_f(N) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [SW-1:0]     s,
   input  logic [W-1:0]      i_data,
   input  logic              i_valid,
   output logic              i_ready,
   output logic [N*W-1:0]    m_data,
   output logic [N-1:0]      m_valid,
   input  logic [N-1:0]      m_ready,
   output logic [DROP_W-1:0] drop_cnt
);

   logic [N-1:0]      load;
   logic [N-1:0]      slot_free;
   logic              in_range;
   logic              sel_free;
   logic              accept;
   logic [DROP_W-1:0] drop_q;
   logic [DROP_W-1:0] drop_d;

   // Loop-based decode avoids indexing slot_free with an out-of-range select.
   always_comb begin
      load     = '0;
      in_range = 1'b0;
      sel_free = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (s == SW'(k)) begin
            in_range = 1'b1;
            sel_free = slot_free[k];
         end
      end
      i_ready = en & (~in_range | sel_free);
      accept  = i_valid & i_ready;
      for (int k = 0; k < N; k++) begin
         load[k] = accept & (s == SW'(k));
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (accept && !in_range && (drop_q != {DROP_W{1'b1}})) begin
         drop_d = drop_q + DROP_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt = drop_q;

   for (genvar k = 0; k < N; k++) begin : g_slot
      demux_slot #(
         .W(W)
      ) u_slot (
         .clk    (clk),
         .rst_n  (rst_n),
         .load_i (load[k]),
         .data_i (i_data),
         .ready_i(m_ready[k]),
         .valid_o(m_valid[k]),
         .data_o (m_data[k*W +: W]),
         .free_o (slot_free[k])
      );
   end

endmodule
